// File: rtl/carry_skip_pkg.sv
// Shared defaults and stage payload type for the pipelined carry-skip adder.
package carry_skip_pkg;

    localparam int unsigned CSP_WIDTH  = 16;
    localparam int unsigned CSP_BLOCK  = 4;
    localparam int unsigned CSP_STAGES = CSP_WIDTH / CSP_BLOCK;

    // One pipeline slot at the default geometry: operands not yet consumed and the sum resolved so far.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [CSP_WIDTH-1:0] opa;
        logic [CSP_WIDTH-1:0] opb;
        logic [CSP_WIDTH-1:0] psum;
    } stage_t;

endpackage

// File: rtl/carry_skip_stage.sv
// One BLOCK-bit ripple slice plus its skip decision; purely combinational, registered by the parent.
module carry_skip_stage #(
    parameter int unsigned BLOCK = 4
) (
    input  logic [BLOCK-1:0] a_blk,
    input  logic [BLOCK-1:0] b_blk,
    input  logic             cin_blk,
    output logic [BLOCK-1:0] sum_blk,
    output logic             cin_next
);

    logic rip_cout;

    // Ripple across the block; rip_cout is the block's own carry-out.
    always_comb begin
        logic c;
        sum_blk  = '0;
        c        = cin_blk;
        for (int i = 0; i < int'(BLOCK); i++) begin
            sum_blk[i] = a_blk[i] ^ b_blk[i] ^ c;
            c          = (a_blk[i] & b_blk[i]) | (c & (a_blk[i] ^ b_blk[i]));
        end
        rip_cout = c;
    end

    skip_logic #(
        .BLOCK (BLOCK)
    ) u_skip (
        .a_blk    (a_blk),
        .b_blk    (b_blk),
        .cin_blk  (cin_blk),
        .cout_blk (rip_cout),
        .cin_next (cin_next)
    );

endmodule

// File: rtl/skip_logic.sv
// Block-level skip decision: the carry leaving a block either comes from its ripple or bypasses it.
module skip_logic #(
    parameter int unsigned BLOCK = 4
) (
    input  logic [BLOCK-1:0] a_blk,
    input  logic [BLOCK-1:0] b_blk,
    input  logic             cin_blk,
    input  logic             cout_blk,
    output logic             cin_next
);

    logic prop;

    assign prop     = &(a_blk | b_blk);
    assign cin_next = cout_blk | (prop & cin_blk);

endmodule

// File: rtl/carry_skip_pipe.sv
// Pipelined carry-skip adder, one skip block resolved per stage, valid/ready on both sides.
// Define CARRY_SKIP_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module carry_skip_pipe
    import carry_skip_pkg::*;
#(
    parameter int unsigned WIDTH = CSP_WIDTH,
    parameter int unsigned BLOCK = CSP_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CARRY_SKIP_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned STAGES = WIDTH / BLOCK;

    if (((WIDTH % BLOCK) != 0) || (STAGES == 0)) begin : g_bad_cfg
        $error("carry_skip_pipe: WIDTH must be a non-zero multiple of BLOCK");
    end

    logic en;

    // The whole pipe advances together; only a held result at the output can stop it.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en & ~rst;

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        localparam int unsigned LO   = k * BLOCK;
        localparam int unsigned SW   = LO + BLOCK;
        localparam bit          LAST = (k == int'(STAGES) - 1);

        logic                  src_vld;
        logic                  src_carry;
        logic [WIDTH-LO-1:0]   src_a;
        logic [WIDTH-LO-1:0]   src_b;
        logic [SW-1:0]         sum_mrg;
        logic [BLOCK-1:0]      sum_blk;
        logic                  cin_next;

        logic                  vld_d, vld_q;
        logic                  carry_d, carry_q;
        logic [SW-1:0]         sum_d, sum_q;

        // Stage 0 reads the ports; later stages read the skewed registers of the stage before.
        if (k == 0) begin : g_src
            assign src_vld   = in_valid & in_ready;
            assign src_carry = cin;
            assign src_a     = a;
            assign src_b     = b;
            assign sum_mrg   = sum_blk;
        end else begin : g_src
            assign src_vld   = g_stage[k-1].vld_q;
            assign src_carry = g_stage[k-1].carry_q;
            assign src_a     = g_stage[k-1].g_rem.opa_q;
            assign src_b     = g_stage[k-1].g_rem.opb_q;
            assign sum_mrg   = {sum_blk, g_stage[k-1].sum_q};
        end

        carry_skip_stage #(
            .BLOCK (BLOCK)
        ) u_blk (
            .a_blk    (src_a[BLOCK-1:0]),
            .b_blk    (src_b[BLOCK-1:0]),
            .cin_blk  (src_carry),
            .sum_blk  (sum_blk),
            .cin_next (cin_next)
        );

        always_comb begin
            vld_d   = vld_q;
            carry_d = carry_q;
            sum_d   = sum_q;
            if (en) begin
                vld_d   = src_vld;
                carry_d = cin_next;
                sum_d   = sum_mrg;
            end
        end

        // Only the final stage doubles as the output register and has its data cleared.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                if (LAST) begin
                    carry_q <= 1'b0;
                    sum_q   <= '0;
                end
            end else begin
                vld_q   <= vld_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        if (!LAST) begin : g_rem
            logic [WIDTH-SW-1:0] opa_d, opa_q;
            logic [WIDTH-SW-1:0] opb_d, opb_q;

            always_comb begin
                opa_d = opa_q;
                opb_d = opb_q;
                if (en) begin
                    opa_d = src_a[WIDTH-LO-1:BLOCK];
                    opb_d = src_b[WIDTH-LO-1:BLOCK];
                end
            end

            always_ff @(posedge clk) begin
                opa_q <= opa_d;
                opb_q <= opb_d;
            end
        end

`ifdef CARRY_SKIP_PIPE_OVF_EN
        // The operand sign bits reach the last stage as the top of its unconsumed block.
        if (LAST) begin : g_ovf
            logic ovf_d, ovf_q;

            always_comb begin
                ovf_d = ovf_q;
                if (en) begin
                    ovf_d = (src_a[WIDTH-LO-1] == src_b[WIDTH-LO-1]) &
                            (sum_blk[BLOCK-1] != src_a[WIDTH-LO-1]);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;
`ifdef CARRY_SKIP_PIPE_OVF_EN
    assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_carry_skip_pipe.sv
// Self-checking bench for carry_skip_pipe (WIDTH=16, BLOCK=4); checks ovf when CARRY_SKIP_PIPE_OVF_EN is defined.
`timescale 1ns/1ps
module tb_carry_skip_pipe;

    localparam int unsigned W   = 16;
    localparam int unsigned STG = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CARRY_SKIP_PIPE_OVF_EN
    logic         ovf;
`endif

    carry_skip_pipe #(
        .WIDTH (W),
        .BLOCK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CARRY_SKIP_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           t_acc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    exp_t         exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           n_pop = 0;
    int           stall_seen = 0;
    int           last_lat = -1;
    logic [W-1:0] last_sum;
    logic         last_cout;
`ifdef CARRY_SKIP_PIPE_OVF_EN
    logic         last_ovf;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain wide addition, independent of block structure.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int t);
        exp_t         e;
        logic [W:0]   s;
        s       = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.sum   = s[W-1:0];
        e.cout  = s[W];
        e.ovf   = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        e.t_acc = t;
        return e;
    endfunction

    // One clock: drive at the falling edge, score the upcoming rising edge, return at the next falling edge.
    task automatic step(input logic r, input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic ordy, output logic acc);
        exp_t e;
        rst       = r;
        in_valid  = v;
        a         = av;
        b         = bv;
        cin       = cv;
        out_ready = ordy;
        #1;
        acc = in_valid & in_ready;
        if (r) chk("in_ready_during_rst", 32'(in_ready), 32'(0));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale_result: got out_valid=1 sum=%0h expected no result (cycle %0d)", sum, cyc);
            end else begin
                e = exp_q[0];
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
`ifdef CARRY_SKIP_PIPE_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
                if (!out_ready) begin
                    stall_seen++;
                    chk("in_ready_while_stalled", 32'(in_ready), 32'(0));
                end else begin
                    void'(exp_q.pop_front());
                    n_pop++;
                    last_lat  = cyc - e.t_acc;
                    last_sum  = sum;
                    last_cout = cout;
`ifdef CARRY_SKIP_PIPE_OVF_EN
                    last_ovf  = ovf;
`endif
                end
            end
        end
        if (r) exp_q.delete();
        else if (acc) exp_q.push_back(model(av, bv, cv, cyc));
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input string nm);
        logic acc;
        int   w;
        w = 0;
        while (exp_q.size() != 0 && w < 40) begin
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
            w++;
        end
        chk(nm, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        logic acc;
        int   j;
        int   p0;
        int   sent;

        vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vt[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vt[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[7] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[8] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
`ifdef CARRY_SKIP_PIPE_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'(0));
`endif

        // Isolated vectors: known answers and exact latency through an empty pipe.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, vt[i].a, vt[i].b, vt[i].cin, 1'b1, acc);
            chk("tbl_accept", 32'(acc), 32'(1));
            drain("tbl_drain");
            chk("tbl_latency", 32'(last_lat), 32'(STG));
            chk("tbl_sum", 32'(last_sum), 32'(vt[i].sum));
            chk("tbl_cout", 32'(last_cout), 32'(vt[i].cout));
`ifdef CARRY_SKIP_PIPE_OVF_EN
            chk("tbl_ovf", 32'(last_ovf), 32'(vt[i].ovf));
`endif
        end

        // Six back-to-back operands with the consumer stalling for three cycles.
        j = 0; p0 = n_pop; stall_seen = 0;
        for (int i = 0; i < 40 && (j < 6 || exp_q.size() != 0); i++) begin
            step(1'b0, j < 6, W'(j * 16'h1357 + 16'h0101), W'(j * 16'h2468), j[0],
                 !(i >= 5 && i <= 7), acc);
            if (acc) j++;
        end
        chk("stall_accepted", 32'(j), 32'(6));
        chk("stall_delivered", 32'(n_pop - p0), 32'(6));
        chk("stall_cycles", 32'(stall_seen), 32'(3));
        chk("stall_drained", 32'(exp_q.size()), 32'(0));

        // Reset with three operands in flight; a simultaneous in_valid must not be taken.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'(16'h1111 * (i + 1)), 16'h0F0F, 1'b1, 1'b1, acc);
        step(1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1, acc);
        chk("rst_no_accept", 32'(acc), 32'(0));
        chk("out_valid_after_rst", 32'(out_valid), 32'(0));
        p0 = n_pop;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("rst_no_results", 32'(n_pop - p0), 32'(0));
        step(1'b0, 1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1, acc);
        drain("post_rst_drain");
        chk("post_rst_latency", 32'(last_lat), 32'(STG));
        chk("post_rst_sum", 32'(last_sum), 32'(16'h0100));

        // Random operands and random backpressure against the reference.
        sent = 0; p0 = n_pop;
        for (int i = 0; i < 60000 && (sent < 10000 || exp_q.size() != 0); i++) begin
            step(1'b0, (sent < 10000) && ($urandom_range(0, 9) < 8), W'($urandom), W'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, acc);
            if (acc) sent++;
        end
        chk("rand_sent", 32'(sent), 32'(10000));
        chk("rand_delivered", 32'(n_pop - p0), 32'(10000));
        chk("rand_drained", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
